// File: rtl/qenc_pkg.sv
`default_nettype none
// qenc_pkg: shared state, error and configuration-bus encodings for the encoder controller.
// Rev 1.0
package qenc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEEK  = 3'd1,
    ALIGN = 3'd2,
    RUN   = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;

  localparam logic [1:0] CFG_ADDR_PPR = 2'd0;
  localparam logic [1:0] CFG_ADDR_CMD = 2'd1;

  localparam int CMD_START       = 0;
  localparam int CMD_CLEAR_FAULT = 1;
  localparam int CMD_ABORT       = 2;

endpackage
`default_nettype wire

// File: rtl/qenc_home_ctrl_if.sv
`default_nettype none
// qenc_home_ctrl_if: host configuration write bus (single-cycle write strobe).
// Rev 1.0
interface qenc_home_ctrl_if;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;

  modport master (output cfg_we, cfg_addr, cfg_wdata);
  modport slave  (input  cfg_we, cfg_addr, cfg_wdata);
endinterface
`default_nettype wire

// File: rtl/qenc_input_filter.sv
`default_nettype none
// qenc_input_filter: 2-flop synchronizer followed by a FILT_LEN-sample stability filter.
// Rev 1.0
module qenc_input_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic filt
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // cnt counts consecutive synchronized samples that disagree with filt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      filt  <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/qenc_home_ctrl.sv
`default_nettype none
// qenc_home_ctrl: conditions encoder pins, homes on index, supervises the decoder and
// samples wrap-corrected velocity. Optional index re-check: QENC_CTRL_IDX_CHECK_EN. Rev 1.0
module qenc_home_ctrl
  import qenc_pkg::*;
#(
  parameter int PPR_W        = 10,
  parameter int FILT_LEN     = 3,
  parameter int SAMPLE_DIV   = 1000,
  parameter int HOME_TIMEOUT = 1048576
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_raw,
  input  logic                    b_raw,
  input  logic                    idx_raw,
  qenc_home_ctrl_if.slave         cfg,
  output logic                    enc_a,
  output logic                    enc_b,
  output logic                    enc_rst,
  output logic [PPR_W-1:0]        enc_ppr,
  input  logic signed [PPR_W-1:0] enc_p,
  output logic                    busy,
  output logic                    home_done,
  output logic [1:0]              err_code,
  output logic signed [PPR_W+1:0] vel,
  output logic                    vel_valid,
  output logic                    idx_slip
);

  localparam int VW   = PPR_W + 2;
  localparam int TO_W = $clog2(HOME_TIMEOUT + 1);
  localparam int SD_W = $clog2(SAMPLE_DIV + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(HOME_TIMEOUT - 1);
  localparam logic [SD_W-1:0] SD_LAST = SD_W'(SAMPLE_DIV - 1);

  state_t          state, state_nxt;
  logic [1:0]      fault_code;
  logic            idx_filt, a_prev, b_prev, idx_prev;
  logic            illegal, idx_rise;
  logic            cmd_we, cmd_start, cmd_clear, cmd_abort;
  logic [TO_W-1:0] tcnt;
  logic [SD_W-1:0] scnt;
  logic            slip_det, rezero;
  logic            unused_wdata;

  logic [VW-1:0]        ppr_p1;
  logic signed [VW-1:0] half, span, p_ext, prev_p, diff, vel_wrap;

  qenc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a   (.clk(clk), .reset(reset), .pin(a_raw),   .filt(enc_a));
  qenc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b   (.clk(clk), .reset(reset), .pin(b_raw),   .filt(enc_b));
  qenc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_idx (.clk(clk), .reset(reset), .pin(idx_raw), .filt(idx_filt));

  assign unused_wdata = ^cfg.cfg_wdata[15:PPR_W];

  // Command decode resolves priority abort > clear_fault > start
  assign cmd_we    = cfg.cfg_we && (cfg.cfg_addr == CFG_ADDR_CMD);
  assign cmd_abort = cmd_we && cfg.cfg_wdata[CMD_ABORT];
  assign cmd_clear = cmd_we && cfg.cfg_wdata[CMD_CLEAR_FAULT] && !cfg.cfg_wdata[CMD_ABORT];
  assign cmd_start = cmd_we && cfg.cfg_wdata[CMD_START] && !cfg.cfg_wdata[CMD_CLEAR_FAULT]
                     && !cfg.cfg_wdata[CMD_ABORT];

  assign illegal  = (enc_a != a_prev) && (enc_b != b_prev);
  assign idx_rise = idx_filt && !idx_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_prev   <= 1'b0;
      b_prev   <= 1'b0;
      idx_prev <= 1'b0;
      enc_ppr  <= '0;
      tcnt     <= '0;
    end else begin
      a_prev   <= enc_a;
      b_prev   <= enc_b;
      idx_prev <= idx_filt;
      if (cfg.cfg_we && (cfg.cfg_addr == CFG_ADDR_PPR) && ((state == IDLE) || (state == FAULT)))
        enc_ppr <= cfg.cfg_wdata[PPR_W-1:0];
      tcnt <= (state == SEEK) ? tcnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      err_code <= ERR_NONE;
    end else begin
      state <= state_nxt;
      if (state_nxt == IDLE)
        err_code <= ERR_NONE;
      else if (fault_code != ERR_NONE)
        err_code <= fault_code;
    end
  end

  always_comb begin
    state_nxt  = state;
    fault_code = ERR_NONE;
    busy       = (state == SEEK) || (state == ALIGN);
    home_done  = (state == RUN);
    enc_rst    = !((state == SEEK) || (state == RUN)) || rezero;
    if (cmd_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (cmd_start) state_nxt = SEEK;
        SEEK: begin
          if (illegal) begin
            state_nxt  = FAULT;
            fault_code = ERR_ILLEGAL;
          end else if (idx_rise) begin
            state_nxt = ALIGN;
          end else if (tcnt == TO_LAST) begin
            state_nxt  = FAULT;
            fault_code = ERR_TIMEOUT;
          end
        end
        ALIGN: state_nxt = RUN;
        RUN: begin
          if (illegal) begin
            state_nxt  = FAULT;
            fault_code = ERR_ILLEGAL;
          end
        end
        FAULT: if (cmd_clear) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef QENC_CTRL_IDX_CHECK_EN
  // An index edge in RUN must coincide with position zero; otherwise re-zero the decoder
  assign slip_det = (state == RUN) && idx_rise && (enc_p != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rezero   <= 1'b0;
      idx_slip <= 1'b0;
    end else begin
      rezero <= slip_det;
      if (cmd_abort)
        idx_slip <= 1'b0;
      else if (slip_det)
        idx_slip <= 1'b1;
    end
  end
`else
  assign slip_det = 1'b0;
  assign rezero   = 1'b0;
  assign idx_slip = 1'b0;
`endif

  // Decoder span M = 2*floor((PPR+1)/2); deltas beyond +-M/2 are taken as wraps
  assign ppr_p1 = {2'b00, enc_ppr} + VW'(1);
  assign half   = $signed(ppr_p1 >> 1);
  assign span   = half <<< 1;
  assign p_ext  = {{2{enc_p[PPR_W-1]}}, enc_p};
  assign diff   = p_ext - prev_p;

  always_comb begin
    vel_wrap = diff;
    if (diff > half)
      vel_wrap = diff - span;
    else if (diff < -half)
      vel_wrap = diff + span;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt      <= '0;
      prev_p    <= '0;
      vel       <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      if (state != RUN) begin
        scnt   <= '0;
        prev_p <= '0;
      end else begin
        if (scnt == SD_LAST) begin
          scnt      <= '0;
          vel       <= vel_wrap;
          vel_valid <= 1'b1;
          prev_p    <= p_ext;
        end else begin
          scnt <= scnt + 1'b1;
        end
        if (slip_det)
          prev_p <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/qenc_home_ctrl.md
# qenc_home_ctrl

Controller that sequences the quadrature encoder decoder: conditions raw A/B/index inputs, programs the decoder's PPR, runs an index-based homing sequence, and then supervises the running decoder. It reports illegal transitions and homing timeouts, and produces periodic wrap-corrected velocity samples from the decoder's signed position. It sits between the encoder pins / host configuration bus and the decoder instance.

## Interface
- PPR_W, 10: PPR and position width (matches decoder)
- FILT_LEN, 3: cycles a synchronized input must be stable before the filtered value changes
- SAMPLE_DIV, 1000: velocity sample period in clk cycles
- HOME_TIMEOUT, 1048576: max cycles in SEEK waiting for index
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- a_raw, b_raw, idx_raw  in  1 each  asynchronous encoder pins
- cfg_we  in  1  config write strobe, one cycle
- cfg_addr  in  2  0 = PPR, 1 = command
- cfg_wdata  in  16  write data; command bits: [0] start, [1] clear_fault, [2] abort
- enc_a, enc_b  out  1 each  filtered A/B to decoder
- enc_rst  out  1  decoder reset
- enc_ppr  out  PPR_W  decoder PPR
- enc_p  in  PPR_W signed  decoder position
- busy  out  1  state is SEEK or ALIGN
- home_done  out  1  state is RUN
- err_code  out  2  0 none, 1 timeout, 2 illegal transition; valid in FAULT
- vel  out  PPR_W+2 signed  counts per sample period
- vel_valid  out  1  one-cycle pulse
- idx_slip  out  1  sticky index-mismatch flag (see Configuration)

## Operation
- Reset values: enc_rst=1, enc_ppr=0, enc_a=enc_b=0, busy=0, home_done=0, err_code=0, vel=0, vel_valid=0, idx_slip=0, state IDLE, filters cleared to 0.
- Input path per pin: 2-flop synchronizer, then stability filter. The output takes the synchronized value only after FILT_LEN consecutive equal samples.
- PPR write (addr 0): stores cfg_wdata[PPR_W-1:0] only in IDLE or FAULT. Ignored in any other state.
- Command priority in one write: abort > clear_fault > start.
- States:
  - IDLE: enc_rst=1. start → SEEK.
  - SEEK: enc_rst=0; timeout counter runs.
    - Filtered index rising edge → ALIGN.
    - Counter reaches HOME_TIMEOUT → FAULT, err_code=1.
    - Illegal transition → FAULT, err_code=2.
    - Priority: illegal > index > timeout.
  - ALIGN: enc_rst=1 for exactly one cycle (decoder position zeroes at index) → RUN.
  - RUN: enc_rst=0. Illegal transition → FAULT, err_code=2.
  - FAULT: enc_rst=1; err_code held. clear_fault → IDLE with err_code=0.
  - abort in any state → IDLE; err_code cleared.
- Illegal transition: filtered A and B both change in the same cycle.
- Velocity (RUN only):
  - M = 2·floor((PPR+1)/2), the decoder's position span.
  - Each sample: d = enc_p − prev_p, computed at PPR_W+2 bits. If d > M/2 then d −= M; if d < −M/2 then d += M. Then vel = d and prev_p = enc_p.
  - prev_p = 0 on RUN entry.
  - Leaving RUN: sample counter cleared; vel holds its last value.

## Timing
- Pin to enc_a/enc_b latency: 2 + FILT_LEN cycles.
- start write at cycle t → busy=1 at t+1.
- Index edge seen at t → ALIGN at t+1 (enc_rst=1) → RUN at t+2 (home_done=1, enc_rst=0).
- First vel_valid exactly SAMPLE_DIV cycles after RUN entry, then every SAMPLE_DIV cycles.
- FAULT entry one cycle after the detecting condition; enc_rst=1 in the same cycle.
- Asynchronous reset mid-operation: all outputs return to reset values immediately; no sample or fault is retained.

## Configuration
- QENC_CTRL_IDX_CHECK_EN defined: in RUN, each filtered index rising edge compares enc_p to 0.
  - On mismatch: set idx_slip (sticky; cleared by abort or reset) and pulse enc_rst for one cycle to re-zero the decoder.
  - The velocity sample spanning the re-zero uses prev_p = 0 from that cycle.
- Undefined: index ignored in RUN; idx_slip tied 0.

## Structure
- Package qenc_pkg:
  - state enum (IDLE, SEEK, ALIGN, RUN, FAULT)
  - err_code constants (ERR_NONE, ERR_TIMEOUT, ERR_ILLEGAL)
  - cfg address constants
  - command bit indices
- Sub-module qenc_input_filter (synchronizer + stability filter, FILT_LEN parameter), instantiated three times.

## Test plan
- Write PPR=10, start, index pulse after 50 cycles → busy 1→0, one-cycle enc_rst pulse, home_done=1; enc_p tracked at 0 by decoder model.
- Start with no index, HOME_TIMEOUT=1000 → FAULT at cycle 1001 after start; err_code=1; clear_fault → IDLE, err_code=0.
- In RUN with PPR=10 (M=10), forward 3 counts across wrap 4→−5→… per period, SAMPLE_DIV=100 → vel=+3; reverse 3 counts → vel=−3.
- In RUN, A and B toggle in the same cycle → FAULT, err_code=2, enc_rst=1; PPR write during RUN is ignored, enc_ppr unchanged.
- A 2-cycle glitch on a_raw with FILT_LEN=3 → enc_a unchanged.
- With QENC_CTRL_IDX_CHECK_EN: index in RUN while enc_p=2 → idx_slip=1 and enc_rst pulsed one cycle; abort → IDLE, idx_slip=0.
